// File: rtl/serial_sum_deser.sv
// Deserialises an LSB-first data/carry/parity bit stream into one frame word with parity check.
// Output rises the cycle after the parity bit is accepted; s_ready drops while a frame waits in HOLD.
module serial_sum_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_start,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_sum,
    output logic             m_cout,
    output logic             m_par_err,
    output logic             m_resync
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, DATA, CARRY, PAR, HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_par_err;
    logic             r_resync;
    logic             w_acc;
    logic             w_restart;
    logic [WIDTH-1:0] w_bit0;

    assign w_acc     = s_valid & s_ready;
    assign w_restart = w_acc & s_start &
                       ((r_state == DATA) | (r_state == CARRY) | (r_state == PAR));
    assign w_bit0    = {{(WIDTH-1){1'b0}}, s_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b1;
        m_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc && s_start) w_next = DATA;
            end
            DATA: begin
                if (w_acc && !s_start && (r_cnt == LAST_IDX)) w_next = CARRY;
            end
            CARRY: begin
                if (w_acc) w_next = s_start ? DATA : PAR;
            end
            PAR: begin
                if (w_acc) w_next = s_start ? DATA : HOLD;
            end
            HOLD: begin
                s_ready = 1'b0;
                m_valid = 1'b1;
                if (m_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A start bit anywhere inside a frame throws away the partial word and begins again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_par_err <= 1'b0;
            r_resync  <= 1'b0;
        end else if (w_restart) begin
            r_sum    <= w_bit0;
            r_cnt    <= CW'(1);
            r_resync <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc && s_start) begin
                        r_sum <= w_bit0;
                        r_cnt <= CW'(1);
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_sum <= r_sum | (w_bit0 << r_cnt);
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CARRY: begin
                    if (w_acc) r_cout <= s_bit;
                end
                PAR: begin
                    if (w_acc) r_par_err <= ^{r_sum, r_cout, s_bit};
                end
                HOLD: begin
                    if (m_ready) r_resync <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign m_sum     = r_sum;
    assign m_cout    = r_cout;
    assign m_par_err = r_par_err;
    assign m_resync  = r_resync & (r_state == HOLD);

endmodule

// File: tb/tb_serial_sum_deser.sv
// Bench for serial_sum_deser: table of frames plus directed hold, restart and reset sequences.
module tb_serial_sum_deser;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_bit = 1'b0;
    logic             s_start = 1'b0;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_par_err;
    logic             m_resync;

    serial_sum_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .s_start   (s_start),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_cout    (m_cout),
        .m_par_err (m_par_err),
        .m_resync  (m_resync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       perr;
        logic       resync;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic       par;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_perr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int hi_cnt = 0;
    int last_width = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] s, input logic c, input logic p, input logic r);
        exp_t e;
        e.sum = s; e.cout = c; e.perr = p; e.resync = r;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Output monitor: pops the scoreboard on every handshake, tracks valid pulse width and rise time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) begin
                check("hold_s_ready", {31'b0, s_ready}, 32'd0);
                if (!prev_vld) rise_cyc = cyc;
                hi_cnt++;
            end else if (prev_vld) begin
                last_width = hi_cnt;
                hi_cnt = 0;
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got sum 0x%0h, no frame expected", m_sum);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_popped++;
                    check("m_sum", {24'b0, m_sum}, {24'b0, e.sum});
                    check("m_cout", {31'b0, m_cout}, {31'b0, e.cout});
                    check("m_par_err", {31'b0, m_par_err}, {31'b0, e.perr});
                    check("m_resync", {31'b0, m_resync}, {31'b0, e.resync});
                end
            end
            prev_vld = m_valid;
        end else begin
            prev_vld = 1'b0;
            hi_cnt = 0;
        end
    end

    task automatic send_bit(input logic b, input logic st, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_bit   = b;
        s_start = st;
        if (st) start_cyc = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic c, input logic p, input bit gaps);
        for (int i = 0; i < WIDTH; i++) send_bit(d[i], (i == 0), gaps);
        send_bit(c, 1'b0, gaps);
        send_bit(p, 1'b0, gaps);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("release_timeout", {31'b0, m_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_sum", {24'b0, m_sum}, 32'd0);
        check("rst_m_cout", {31'b0, m_cout}, 32'd0);
        check("rst_m_par_err", {31'b0, m_par_err}, 32'd0);
        check("rst_m_resync", {31'b0, m_resync}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);

        // Table-driven frames, no gaps, downstream always ready
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_perr, 1'b0);
            send_frame(vecs[i].data, vecs[i].carry, vecs[i].par, 1'b0);
            wait_idle();
            @(negedge clk);
            #1;
            check("latency", rise_cyc - start_cyc, 32'd10);
            check("valid_width", last_width, 32'd1);
        end

        // Gapped frame held by backpressure; bits offered during HOLD must be ignored
        m_ready = 1'b0;
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_start = 1'b1;
            s_bit   = 1'b1;
            @(negedge clk);
            check("hold_m_valid", {31'b0, m_valid}, 32'd1);
            check("hold_m_sum", {24'b0, m_sum}, 32'h3C);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_start = 1'b0;
        m_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("post_hold_idle", {31'b0, m_valid}, 32'd0);

        // Restart at data bit 4
        push_exp(8'h0F, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 0), 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Restart where the carry bit would be: old all-ones data must be cleared
        push_exp(8'h96, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0), 1'b0);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Restart where the parity bit would be
        push_exp(8'h33, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send_bit(1'b1, (i == 0), 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Async reset while in CARRY, release with a start bit in the same cycle
        for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_sum", {24'b0, m_sum}, 32'd0);
        check("async_rst_m_valid", {31'b0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Stray non-start bits in IDLE are discarded
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        check("frames_seen", n_popped, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
